// File: rtl/fftstg_sdf.sv
// fftstg_sdf: radix-2 single-path delay-feedback (R2SDF) FFT stage.
//   One instance per pipeline position. The delay depth D = 2^(M-1) is set by
//   parameter M, so the same module serves every stage of a 2^N-point FFT.
//   The stage performs the butterfly and the reorder only; twiddle
//   multiplication happens downstream.
//   Samples may arrive with gaps. The stage advances only on a "step", which
//   is an accepted input sample or a flush cycle that drains with zero input.
//   Optional feature: define FFTSTG_SCALE_EN to halve both butterfly results
//   with round-half-up. Otherwise each WIDTH+1 bit sum wraps to WIDTH bits.
module fftstg_sdf #(
  parameter int WIDTH = 16,
  parameter int N     = 9,
  parameter int M     = 9
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             en_in,
  input  logic             flush,
  input  logic [N-1:0]     cnt_in,
  input  logic [WIDTH-1:0] xin_re,
  input  logic [WIDTH-1:0] xin_im,
  output logic             en_out,
  output logic [N-1:0]     cnt_out,
  output logic [WIDTH-1:0] yout_re,
  output logic [WIDTH-1:0] yout_im
);

  localparam int             D        = 1 << (M - 1);
  localparam int             PW       = (M > 1) ? (M - 1) : 1;
  localparam logic [PW-1:0]  PTR_LAST = PW'(D - 1);
  localparam logic [N-1:0]   D_CNT    = N'(D);

  // Bring a WIDTH+1 bit butterfly sum back down to WIDTH bits.
  function automatic logic [WIDTH-1:0] reduce(input logic [WIDTH:0] s);
`ifdef FFTSTG_SCALE_EN
    logic [WIDTH:0] r;
    r = s + 1'b1;
    return r[WIDTH:1];
`else
    return s[WIDTH-1:0];
`endif
  endfunction

  // Delay line storage, organised as a circular buffer.
  logic [WIDTH-1:0] r_dl_re [D];
  logic [WIDTH-1:0] r_dl_im [D];
  logic [PW-1:0]    r_ptr;

  // Control and output registers.
  logic [N-1:0]     r_cnt_exp;
  logic             r_primed;
  logic             r_en_out;
  logic [N-1:0]     r_cnt_out;
  logic [WIDTH-1:0] r_y_re;
  logic [WIDTH-1:0] r_y_im;

  // Step qualification. en_in takes priority over flush. A flush cycle uses
  // the expected index and a zero sample.
  logic             w_step;
  logic [N-1:0]     w_cnt;
  logic [WIDTH-1:0] w_x_re;
  logic [WIDTH-1:0] w_x_im;
  logic             w_sel;
  logic             w_primed_next;

  assign w_step        = en_in | flush;
  assign w_cnt         = en_in ? cnt_in : r_cnt_exp;
  assign w_x_re        = en_in ? xin_re : '0;
  assign w_x_im        = en_in ? xin_im : '0;
  assign w_sel         = w_cnt[M-1];
  assign w_primed_next = r_primed | w_sel;

  // Butterfly datapath. The delay line head d pairs with the current input x.
  logic [WIDTH-1:0] w_d_re;
  logic [WIDTH-1:0] w_d_im;
  logic [WIDTH:0]   w_sum_re;
  logic [WIDTH:0]   w_sum_im;
  logic [WIDTH:0]   w_dif_re;
  logic [WIDTH:0]   w_dif_im;
  logic [WIDTH-1:0] w_out_re;
  logic [WIDTH-1:0] w_out_im;
  logic [WIDTH-1:0] w_push_re;
  logic [WIDTH-1:0] w_push_im;

  assign w_d_re   = r_dl_re[r_ptr];
  assign w_d_im   = r_dl_im[r_ptr];
  assign w_sum_re = {w_d_re[WIDTH-1], w_d_re} + {w_x_re[WIDTH-1], w_x_re};
  assign w_sum_im = {w_d_im[WIDTH-1], w_d_im} + {w_x_im[WIDTH-1], w_x_im};
  assign w_dif_re = {w_d_re[WIDTH-1], w_d_re} - {w_x_re[WIDTH-1], w_x_re};
  assign w_dif_im = {w_d_im[WIDTH-1], w_d_im} - {w_x_im[WIDTH-1], w_x_im};

  // First half of a block: store x and emit the stored y1 from the previous
  // block. Second half: emit y0 = d+x and store y1 = d-x.
  assign w_out_re  = w_sel ? reduce(w_sum_re) : w_d_re;
  assign w_out_im  = w_sel ? reduce(w_sum_im) : w_d_im;
  assign w_push_re = w_sel ? reduce(w_dif_re) : w_x_re;
  assign w_push_im = w_sel ? reduce(w_dif_im) : w_x_im;

  // Delay line: write at the head and advance the pointer on every step.
  // NOTE: the storage is cleared on reset so no value from before the reset
  // can reach an output. That is why it maps to flops and not to a RAM macro.
  always_ff @(posedge clk) begin
    if (areset) begin
      r_ptr <= '0;
      for (int i = 0; i < D; i++) begin
        r_dl_re[i] <= '0;
        r_dl_im[i] <= '0;
      end
    end else if (w_step) begin
      r_dl_re[r_ptr] <= w_push_re;
      r_dl_im[r_ptr] <= w_push_im;
      r_ptr          <= (r_ptr == PTR_LAST) ? '0 : r_ptr + 1'b1;
    end
  end

  // Output registers, the prime flag and the expected-index tracker.
  // NOTE: non-blocking assignments here let every register sample the
  // pre-edge values, so evaluation order inside the block does not matter.
  always_ff @(posedge clk) begin
    if (areset) begin
      r_en_out  <= 1'b0;
      r_cnt_out <= '0;
      r_y_re    <= '0;
      r_y_im    <= '0;
      r_primed  <= 1'b0;
      r_cnt_exp <= '0;
    end else if (w_step) begin
      r_en_out  <= w_primed_next;
      r_cnt_out <= w_cnt - D_CNT;
      r_y_re    <= w_out_re;
      r_y_im    <= w_out_im;
      r_primed  <= w_primed_next;
      r_cnt_exp <= w_cnt + 1'b1;
    end else begin
      r_en_out  <= 1'b0;
    end
  end

  assign en_out  = r_en_out;
  assign cnt_out = r_cnt_out;
  assign yout_re = r_y_re;
  assign yout_im = r_y_im;

endmodule

// File: tb/tb_fftstg_sdf.sv
// tb_fftstg_sdf: randomized self-checking bench for fftstg_sdf.
//   Three stages share one input stream: (N=3,M=3), (N=3,M=1) and (N=4,M=4).
//   The reference model keeps the log of accepted samples and forms each
//   butterfly output from the sample indices: y0 = x[k]+x[k+D] and
//   y1 = x[k]-x[k+D]. The model honours FFTSTG_SCALE_EN when it is defined.
module tb_fftstg_sdf;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       areset;
  logic       en_in;
  logic       flush;
  logic [3:0] cnt_raw;
  logic [W-1:0] xin_re;
  logic [W-1:0] xin_im;

  logic         a_en, b_en, c_en;
  logic [2:0]   a_cnt, b_cnt;
  logic [3:0]   c_cnt;
  logic [W-1:0] a_re, a_im, b_re, b_im, c_re, c_im;

  always #5 clk = ~clk;

  fftstg_sdf #(.WIDTH(W), .N(3), .M(3)) u_a (
    .clk(clk), .areset(areset), .en_in(en_in), .flush(flush),
    .cnt_in(cnt_raw[2:0]), .xin_re(xin_re), .xin_im(xin_im),
    .en_out(a_en), .cnt_out(a_cnt), .yout_re(a_re), .yout_im(a_im));

  fftstg_sdf #(.WIDTH(W), .N(3), .M(1)) u_b (
    .clk(clk), .areset(areset), .en_in(en_in), .flush(flush),
    .cnt_in(cnt_raw[2:0]), .xin_re(xin_re), .xin_im(xin_im),
    .en_out(b_en), .cnt_out(b_cnt), .yout_re(b_re), .yout_im(b_im));

  fftstg_sdf #(.WIDTH(W), .N(4), .M(4)) u_c (
    .clk(clk), .areset(areset), .en_in(en_in), .flush(flush),
    .cnt_in(cnt_raw), .xin_re(xin_re), .xin_im(xin_im),
    .en_out(c_en), .cnt_out(c_cnt), .yout_re(c_re), .yout_im(c_im));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference model state.
  int      kn[3] = '{3, 3, 4};
  int      km[3] = '{3, 1, 4};
  string   nm[3] = '{"A", "B", "C"};
  int      xr_q[$];
  int      xi_q[$];
  int      c_q[$];
  int      tcnt;
  bit      prim[3];
  int      e_en[3], e_cnt[3], e_re[3], e_im[3];

  // Captured outputs for the directed frame checks.
  bit      capture;
  int      cap_a[$];
  int      cap_b[$];

  function automatic int red(input int s);
    int r;
    r = s;
`ifdef FFTSTG_SCALE_EN
    r = (r + 1) >>> 1;
`endif
    r = r & 255;
    if (r > 127) r = r - 256;
    return r;
  endfunction

  function automatic int at(input int idx, input bit im);
    if (idx < 0) return 0;
    return im ? xi_q[idx] : xr_q[idx];
  endfunction

  task automatic model_reset();
    xr_q.delete(); xi_q.delete(); c_q.delete();
    tcnt = 0;
    for (int k = 0; k < 3; k++) begin
      prim[k] = 1'b0; e_en[k] = 0; e_cnt[k] = 0; e_re[k] = 0; e_im[k] = 0;
    end
  endtask

  task automatic model_step(input int xr, input int xi);
    int i, c, d, bsel;
    xr_q.push_back(xr); xi_q.push_back(xi); c_q.push_back(tcnt);
    i = xr_q.size() - 1;
    c = tcnt;
    tcnt++;
    for (int k = 0; k < 3; k++) begin
      d    = 1 << (km[k] - 1);
      bsel = (c >> (km[k] - 1)) & 1;
      if (bsel == 1) prim[k] = 1'b1;
      e_en[k]  = prim[k] ? 1 : 0;
      e_cnt[k] = (c - d) & ((1 << kn[k]) - 1);
      if (bsel == 1) begin
        e_re[k] = red(at(i - d, 0) + at(i, 0));
        e_im[k] = red(at(i - d, 1) + at(i, 1));
      end else if (prim[k]) begin
        e_re[k] = red(at(i - 2*d, 0) - at(i - d, 0));
        e_im[k] = red(at(i - 2*d, 1) - at(i - d, 1));
      end else begin
        e_re[k] = 0;
        e_im[k] = 0;
      end
    end
  endtask

  // Apply one cycle of stimulus, advance the model and compare all outputs.
  task automatic cycle(input bit rst, input bit en, input bit fl,
                       input int xr, input int xi);
    int g_en[3], g_cnt[3], g_re[3], g_im[3];
    logic [3:0] rnd;
    areset = rst;
    en_in  = en;
    flush  = fl;
    xin_re = W'(xr);
    xin_im = W'(xi);
    rnd    = 4'($urandom);
    cnt_raw = en ? 4'(tcnt) : rnd;
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
    end else if (en || fl) begin
      model_step(en ? xr : 0, en ? xi : 0);
    end else begin
      for (int k = 0; k < 3; k++) e_en[k] = 0;
    end
    g_en[0] = int'(a_en); g_cnt[0] = int'(a_cnt);
    g_re[0] = int'($signed(a_re)); g_im[0] = int'($signed(a_im));
    g_en[1] = int'(b_en); g_cnt[1] = int'(b_cnt);
    g_re[1] = int'($signed(b_re)); g_im[1] = int'($signed(b_im));
    g_en[2] = int'(c_en); g_cnt[2] = int'(c_cnt);
    g_re[2] = int'($signed(c_re)); g_im[2] = int'($signed(c_im));
    for (int k = 0; k < 3; k++) begin
      check({nm[k], "_en"},  g_en[k],  e_en[k]);
      check({nm[k], "_cnt"}, g_cnt[k], e_cnt[k]);
      check({nm[k], "_re"},  g_re[k],  e_re[k]);
      check({nm[k], "_im"},  g_im[k],  e_im[k]);
    end
    if (capture && g_en[0] == 1) cap_a.push_back(g_re[0]);
    if (capture && g_en[1] == 1) cap_b.push_back(g_re[1]);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 0, 0);
  endtask

  int exp_a[8];
  int exp_b[8];
  int r;

  initial begin
    areset = 1'b1; en_in = 1'b0; flush = 1'b0; cnt_raw = '0;
    xin_re = '0; xin_im = '0;
    capture = 1'b0;
    model_reset();
`ifdef FFTSTG_SCALE_EN
    exp_a = '{3, 4, 5, 6, -2, -2, -2, -2};
    exp_b = '{2, 0, 4, 0, 6, 0, 8, 0};
`else
    exp_a = '{6, 8, 10, 12, -4, -4, -4, -4};
    exp_b = '{3, -1, 7, -1, 11, -1, 15, -1};
`endif

    // Reset values.
    do_reset(2);

    // Directed frame x=1..8, then four flush cycles.
    capture = 1'b1;
    for (int i = 1; i <= 8; i++) cycle(1'b0, 1'b1, 1'b0, i, 0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, 0, 0);
    capture = 1'b0;
    check("dirA_count", cap_a.size(), 8);
    for (int i = 0; i < 8 && i < cap_a.size(); i++)
      check($sformatf("dirA_y%0d", i), cap_a[i], exp_a[i]);
    check("dirB_min_count", (cap_b.size() >= 8) ? 1 : 0, 1);
    for (int i = 0; i < 8 && i < cap_b.size(); i++)
      check($sformatf("dirB_y%0d", i), cap_b[i], exp_b[i]);

    // Same frame with en_in low on every other cycle.
    do_reset(1);
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b0, 1'b1, 1'b0, i, 0);
      cycle(1'b0, 1'b0, 1'b0, 0, 0);
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, 0, 0);

    // Back-to-back frames with no flush in between.
    do_reset(1);
    for (int i = 0; i < 32; i++)
      cycle(1'b0, 1'b1, 1'b0, $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128);

    // Reset after five samples, then a fresh frame.
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, 50 + i, -20 - i);
    do_reset(2);
    for (int i = 0; i < 16; i++)
      cycle(1'b0, 1'b1, 1'b0, $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b1, 0, 0);

    // Random mix of samples, gaps, flushes, both-high and resets.
    for (int n = 0; n < 4000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 2)
        cycle(1'b1, 1'($urandom), 1'($urandom), 0, 0);
      else if (r < 62)
        cycle(1'b0, 1'b1, 1'($urandom),
              $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128);
      else if (r < 75)
        cycle(1'b0, 1'b0, 1'b1, $urandom_range(0, 255) - 128, 0);
      else
        cycle(1'b0, 1'b0, 1'b0, $urandom_range(0, 255) - 128, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
